core_mem_arbiter: RTL
=====================

# core_mem_arbiter

Two-requester arbiter that shares one core memory bus (req/addr/wen/strb/wdata → gnt/err/rdata) between two requester ports, typically instruction fetch (port 0) and load/store (port 1). It sits between the core pipeline and the single memory responder. It locks ownership from first request until grant, so request fields stay stable across wait states, and it applies fixed or round-robin priority when both ports request in the same cycle.

## Interface
- MEM_ADDR_W, 64, address width
- MEM_STRB_W, 8, strobe width
- MEM_DATA_W, 64, data width
- ROUND_ROBIN, 1, 1 = alternate winner on contention; 0 = port 0 always wins
- g_clk  input  1  clock, all state on rising edge
- g_resetn  input  1  asynchronous active-low reset
- p0_req, p1_req  input  1  requester request
- p0_addr, p1_addr  input  MEM_ADDR_W  request address
- p0_wen, p1_wen  input  1  write enable
- p0_strb, p1_strb  input  MEM_STRB_W  write strobe
- p0_wdata, p1_wdata  input  MEM_DATA_W  write data
- p0_gnt, p1_gnt  output  1  transaction complete to requester
- p0_err, p1_err  output  1  response error to requester
- p0_rdata, p1_rdata  output  MEM_DATA_W  read data to requester
- m_req  output  1  request to responder
- m_addr  output  MEM_ADDR_W  forwarded address
- m_wen  output  1  forwarded write enable
- m_strb  output  MEM_STRB_W  forwarded strobe
- m_wdata  output  MEM_DATA_W  forwarded write data
- m_gnt  input  1  responder completion
- m_err  input  1  responder error, valid with m_gnt
- m_rdata  input  MEM_DATA_W  responder read data, valid with m_gnt

## Operation
- Bus rule: a transaction completes in the cycle where req && gnt are both high; err/rdata are valid in that cycle only. A requester holds req and all fields stable from assertion until gnt.
- States: IDLE, OWN0, OWN1. Register `last` records the most recent winner.
- IDLE: winner chosen combinationally. Only p0_req → port 0. Only p1_req → port 1. Both → if ROUND_ROBIN=1, the port that is not `last`; else port 0. The winner's fields drive m_* in the same cycle.
  - Winner completes the same cycle (m_gnt=1): stay in IDLE, `last` ← winner.
  - Otherwise: go to OWNn, `last` ← winner.
- OWNn: m_* driven only from port n; the other port's request is ignored and sees gnt=0.
  - m_gnt=1 → IDLE.
  - pn_req drops without gnt (protocol violation): m_req=0 that cycle, → IDLE, no response delivered.
- Response routing: pn_gnt = m_gnt && (current selected port == n). pn_err gated the same way. pn_rdata = m_rdata when selected, else 0.
- m_req=0 whenever no port is selected; m_addr/m_wen/m_strb/m_wdata are 0 when m_req=0.
- The non-selected port's gnt, err and rdata are always 0.

## Timing
- Reset (g_resetn low, asynchronous): state=IDLE, `last`=1 so port 0 wins the first contention.
  - m_req, p0_gnt, p1_gnt, p0_err, p1_err forced 0 while in reset.
  - m_addr/wen/strb/wdata and p*_rdata are 0 while in reset.
- Reset mid-transaction drops ownership immediately with no response. The responder is reset in the same domain.
- Request-to-bus latency: 0 cycles, combinational path pn_req → m_req.
- Response latency: 0 cycles, m_gnt → pn_gnt combinational. No added wait states.
- Back-to-back: after a completion on port n, the next cycle is IDLE arbitration. A continuously requesting other port wins next under ROUND_ROBIN=1.
- Starvation bound (ROUND_ROBIN=1): a held request is served after at most one transaction of the other port.
- No combinational path from m_gnt to m_req.

## Test plan
- Single port 0 read, addr=0x1000, responder gnt after 3 wait cycles, rdata=0xDEADBEEF → m_addr=0x1000 held for 4 cycles; p0_gnt=1 with p0_rdata=0xDEADBEEF on cycle 4; p1_gnt stays 0.
- Both ports request from reset with zero-wait responder, ROUND_ROBIN=1 → grant order p0, p1, p0, p1 on consecutive cycles. With ROUND_ROBIN=0 → p0 granted every cycle, p1 never.
- Port 0 owns the bus (OWN0, waiting); p1_req rises mid-wait → m_addr stays p0_addr until m_gnt. Next cycle m_addr=p1_addr.
- Write from port 1, strb=0x0F, wdata=0x1122334455667788, responder returns m_err=1 → p1_gnt=1 and p1_err=1 in the same cycle; p0_err=0.
- g_resetn pulsed low while in OWN1 → m_req=0 immediately. After release with both requesting, port 0 wins first.
- Port 0 drops req in OWN0 before gnt → m_req=0 that cycle, state IDLE next cycle, and a pending p1 request is served.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one core memory bus between two requesters.
// Port 0 is typically instruction fetch and port 1 is load/store. Ownership is
// locked from the first request until its grant, so request fields seen by the
// responder stay stable across wait states. Contention in IDLE is resolved by
// round-robin on the most recent winner, or by fixed port-0 priority.
module core_mem_arbiter #(
  parameter int MEM_ADDR_W  = 64,
  parameter int MEM_STRB_W  = 8,
  parameter int MEM_DATA_W  = 64,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  // requester port 0
  input  logic                  p0_req,
  input  logic [MEM_ADDR_W-1:0] p0_addr,
  input  logic                  p0_wen,
  input  logic [MEM_STRB_W-1:0] p0_strb,
  input  logic [MEM_DATA_W-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_err,
  output logic [MEM_DATA_W-1:0] p0_rdata,
  // requester port 1
  input  logic                  p1_req,
  input  logic [MEM_ADDR_W-1:0] p1_addr,
  input  logic                  p1_wen,
  input  logic [MEM_STRB_W-1:0] p1_strb,
  input  logic [MEM_DATA_W-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_err,
  output logic [MEM_DATA_W-1:0] p1_rdata,
  // responder side
  output logic                  m_req,
  output logic [MEM_ADDR_W-1:0] m_addr,
  output logic                  m_wen,
  output logic [MEM_STRB_W-1:0] m_strb,
  output logic [MEM_DATA_W-1:0] m_wdata,
  input  logic                  m_gnt,
  input  logic                  m_err,
  input  logic [MEM_DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;   // most recent winner; reset to 1 so port 0 wins first

  logic   sel_vld;          // some port drives the bus this cycle
  logic   sel_port;         // which port, meaningful only with sel_vld
  logic   sel0, sel1;

  // Select the port that drives the bus this cycle (never depends on m_gnt).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    sel_vld  = 1'b0;
    sel_port = 1'b0;
    // NOTE: the async reset only clears registers; the request->bus path is
    // combinational, so it is gated by g_resetn as well to keep outputs quiet
    // for the whole reset pulse.
    if (g_resetn) begin
      case (state_q)
        OWN0: begin
          sel_vld  = p0_req;
          sel_port = 1'b0;
        end
        OWN1: begin
          sel_vld  = p1_req;
          sel_port = 1'b1;
        end
        default: begin
          sel_vld = p0_req | p1_req;
          if (p0_req && p1_req) begin
            sel_port = ROUND_ROBIN ? ~last_q : 1'b0;
          end else begin
            sel_port = p1_req;
          end
        end
      endcase
    end
  end

  assign sel0 = sel_vld & ~sel_port;
  assign sel1 = sel_vld &  sel_port;

  // Forward the selected port's request fields; the bus is all-zero when idle.
  always_comb begin
    m_req   = sel_vld;
    m_addr  = '0;
    m_wen   = 1'b0;
    m_strb  = '0;
    m_wdata = '0;
    if (sel0) begin
      m_addr  = p0_addr;
      m_wen   = p0_wen;
      m_strb  = p0_strb;
      m_wdata = p0_wdata;
    end else if (sel1) begin
      m_addr  = p1_addr;
      m_wen   = p1_wen;
      m_strb  = p1_strb;
      m_wdata = p1_wdata;
    end
  end

  // Route the response only to the selected port; the other sees zeros.
  always_comb begin
    p0_gnt   = m_gnt & sel0;
    p0_err   = m_err & sel0;
    p0_rdata = sel0 ? m_rdata : '0;
    p1_gnt   = m_gnt & sel1;
    p1_err   = m_err & sel1;
    p1_rdata = sel1 ? m_rdata : '0;
  end

  // Ownership tracking: lock the winner until its grant or until it drops req.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          last_d = sel_port;
          if (!m_gnt) begin
            state_d = sel_port ? OWN1 : OWN0;
          end
        end
      end
      default: begin
        // Completion or an abandoned request both release the bus.
        if (!sel_vld || m_gnt) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule
